// File: rtl/nec_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
// Request FSM states and buffer depth.
package nec_prefetch_queue_pkg;

  localparam int IPQ_BYTES = 8;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_WAIT
  } prefetch_state_e;

endpackage

// File: rtl/nec_prefetch_req.sv
// Code-fetch request/ack/valid handshake FSM.
// Tracks the single outstanding fetch and stale-data discard.
module nec_prefetch_req
  import nec_prefetch_queue_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_issue,
  input  logic        i_set_pc,
  input  logic        i_ack,
  input  logic        i_valid,
  input  logic [14:0] i_word,
  output logic        o_req,
  output logic [15:0] o_addr,
  output logic        o_accept
);

  prefetch_state_e r_state;
  prefetch_state_e w_state_n;
  logic            r_discard;
  logic            w_discard_n;
  logic [14:0]     r_word;
  logic            w_load;

  // Next state, discard tracking and data acceptance
  always_comb begin
    w_state_n   = r_state;
    w_discard_n = r_discard;
    w_load      = 1'b0;
    o_accept    = 1'b0;
    if (i_en) begin
      unique case (r_state)
        PF_IDLE: begin
          if (i_issue && !i_set_pc) begin
            w_state_n = PF_REQ;
            w_load    = 1'b1;
          end
        end
        PF_REQ: begin
          if (i_ack)
            w_state_n = PF_WAIT;
          if (i_set_pc)
            w_discard_n = 1'b1;
        end
        PF_WAIT: begin
          if (i_valid) begin
            w_state_n   = PF_IDLE;
            w_discard_n = 1'b0;
            o_accept    = !r_discard && !i_set_pc;
          end else if (i_set_pc) begin
            w_discard_n = 1'b1;
          end
        end
        default: w_state_n = PF_IDLE;
      endcase
    end
  end

  // State, discard flag and latched request word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= PF_IDLE;
      r_discard <= 1'b0;
      r_word    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_discard <= w_discard_n;
      if (w_load)
        r_word <= i_word;
    end
  end

  assign o_req  = (r_state == PF_REQ);
  assign o_addr = {r_word, 1'b0};

endmodule

// File: rtl/nec_prefetch_queue.sv
// Instruction prefetch queue feeding the decoder.
// 8-byte circular buffer filled by 16-bit code fetches.
module nec_prefetch_queue
  import nec_prefetch_queue_pkg::*;
#(
  parameter int QUEUE_BYTES   = IPQ_BYTES,
  parameter int MIN_FREE_EVEN = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce_1,
  input  logic                        ce_2,
  input  logic [15:0]                 pc,
  input  logic                        set_pc,
  input  logic [15:0]                 new_pc,
  output logic [QUEUE_BYTES-1:0][7:0] ipq,
  output logic [3:0]                  ipq_len,
  output logic                        fetch_req,
  output logic [15:0]                 fetch_addr,
  input  logic                        fetch_ack,
  input  logic                        fetch_valid,
  input  logic [15:0]                 fetch_data
);

  logic [QUEUE_BYTES-1:0][7:0] r_ipq;
  logic [15:0] r_fetch_ptr;
  logic [3:0]  r_len;
  logic        r_running;

  logic        w_en;
  logic [15:0] w_diff;
  logic [3:0]  w_len;
  logic [3:0]  w_free;
  logic [3:0]  w_need;
  logic        w_fit;
  logic        w_issue;
  logic        w_accept;
  logic [2:0]  w_slot;
  logic [2:0]  w_slot_nx;

  assign w_en      = ce_1 | ce_2;
  assign w_diff    = r_fetch_ptr - pc;
  assign w_len     = w_diff[3:0];
  assign w_fit     = (w_diff <= 16'd8);
  assign w_free    = 4'd8 - w_len;
  assign w_need    = r_fetch_ptr[0] ? 4'd1 : 4'(MIN_FREE_EVEN);
  assign w_issue   = r_running && w_fit && (w_free >= w_need);
  assign w_slot    = r_fetch_ptr[2:0];
  assign w_slot_nx = w_slot + 3'd1;

  nec_prefetch_req u_req (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_en),
    .i_issue  (w_issue),
    .i_set_pc (set_pc),
    .i_ack    (fetch_ack),
    .i_valid  (fetch_valid),
    .i_word   (r_fetch_ptr[15:1]),
    .o_req    (fetch_req),
    .o_addr   (fetch_addr),
    .o_accept (w_accept)
  );

  // Fetch pointer, run flag and registered queue length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_ptr <= '0;
      r_running   <= 1'b0;
      r_len       <= '0;
    end else if (w_en) begin
      if (set_pc) begin
        r_fetch_ptr <= new_pc;
        r_running   <= 1'b1;
        r_len       <= '0;
      end else begin
        r_len <= r_running ? w_len : 4'd0;
        if (w_accept)
          r_fetch_ptr <= r_fetch_ptr +
                         (r_fetch_ptr[0] ? 16'd1 : 16'd2);
      end
    end
  end

  // Byte buffer writes; odd pointer takes only the high byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ipq <= '0;
    end else if (w_en && w_accept) begin
      if (r_fetch_ptr[0]) begin
        r_ipq[w_slot] <= fetch_data[15:8];
      end else begin
        r_ipq[w_slot]    <= fetch_data[7:0];
        r_ipq[w_slot_nx] <= fetch_data[15:8];
      end
    end
  end

  assign ipq     = r_ipq;
  assign ipq_len = r_len;

endmodule

// File: tb/tb_nec_prefetch_queue.sv
// Bench for nec_prefetch_queue.
// Vector table plus hand sequences; fetch-address scoreboard.
module tb_nec_prefetch_queue;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ce_1;
  logic            ce_2;
  logic [15:0]     pc;
  logic            set_pc;
  logic [15:0]     new_pc;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic            fetch_req;
  logic [15:0]     fetch_addr;
  logic            fetch_ack;
  logic            fetch_valid;
  logic [15:0]     fetch_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_addr[$];

  typedef struct {
    logic [15:0] npc;
    logic [15:0] data;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [2:0]  slot;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t tbl[4];

  nec_prefetch_queue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_1        (ce_1),
    .ce_2        (ce_2),
    .pc          (pc),
    .set_pc      (set_pc),
    .new_pc      (new_pc),
    .ipq         (ipq),
    .ipq_len     (ipq_len),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && ipq_len > 4'd8) begin
      errors++;
      $display("FAIL len_bound act=%0d max=8", ipq_len);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_addr(string name);
    logic [15:0] e;
    checks++;
    if (q_addr.size() == 0) begin
      errors++;
      $display("FAIL %s act=%h exp=<none>", name, fetch_addr);
    end else begin
      e = q_addr.pop_front();
      if (fetch_addr !== e) begin
        errors++;
        $display("FAIL %s act=%h exp=%h", name, fetch_addr, e);
      end
    end
  endtask

  task automatic wait_req(string name);
    for (int i = 0; i < 20 && !fetch_req; i++)
      tick();
    chk({name, "_req"}, 32'(fetch_req), 32'd1);
  endtask

  task automatic do_ack();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
  endtask

  task automatic do_valid(input logic [15:0] d);
    fetch_valid = 1'b1;
    fetch_data  = d;
    tick();
    fetch_valid = 1'b0;
  endtask

  // Redirect; if a request was left pending, its data is dropped
  task automatic redirect(input logic [15:0] npc,
                          input bit pend, string name);
    set_pc = 1'b1;
    new_pc = npc;
    pc     = npc;
    tick();
    set_pc = 1'b0;
    chk({name, "_flush_len"}, 32'(ipq_len), 32'd0);
    if (pend) begin
      chk({name, "_old_req"}, 32'(fetch_req), 32'd1);
      chk_addr({name, "_old_addr"});
      do_ack();
      do_valid(16'hDEAD);
      tick();
      chk({name, "_drop_len"}, 32'(ipq_len), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0100, 16'hB890, 16'h0100, 4'd2,
               3'd0, 8'h90, 8'hB8};
    tbl[1] = '{16'h2003, 16'h55AA, 16'h2002, 4'd1,
               3'd3, 8'h55, 8'h00};
    tbl[2] = '{16'h00FE, 16'h1234, 16'h00FE, 4'd2,
               3'd6, 8'h34, 8'h12};
    tbl[3] = '{16'h7FFF, 16'hC3A5, 16'h7FFE, 4'd1,
               3'd7, 8'hC3, 8'h00};

    reset_n     = 1'b0;
    ce_1        = 1'b1;
    ce_2        = 1'b0;
    pc          = 16'h0000;
    set_pc      = 1'b0;
    new_pc      = 16'h0000;
    fetch_ack   = 1'b0;
    fetch_valid = 1'b0;
    fetch_data  = 16'h0000;
    tick();
    tick();
    for (int j = 0; j < 8; j++)
      chk($sformatf("rst_ipq%0d", j), 32'(ipq[j]), 32'd0);
    chk("rst_len", 32'(ipq_len), 32'd0);
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_addr", 32'(fetch_addr), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      tick();
    chk("idle_req", 32'(fetch_req), 32'd0);
    chk("idle_len", 32'(ipq_len), 32'd0);

    // One-word fetch per vector; later vectors flush a pending req
    for (int i = 0; i < 4; i++) begin
      redirect(tbl[i].npc, i > 0, $sformatf("v%0d", i));
      q_addr.push_back(tbl[i].addr);
      wait_req($sformatf("v%0d", i));
      chk_addr($sformatf("v%0d_addr", i));
      do_ack();
      do_valid(tbl[i].data);
      tick();
      chk($sformatf("v%0d_len", i), 32'(ipq_len),
          32'(tbl[i].len));
      chk($sformatf("v%0d_b0", i), 32'(ipq[tbl[i].slot]),
          32'(tbl[i].b0));
      if (tbl[i].len == 4'd2)
        chk($sformatf("v%0d_b1", i),
            32'(ipq[3'(tbl[i].slot + 3'd1)]), 32'(tbl[i].b1));
      q_addr.push_back(tbl[i].addr + 16'd2);
    end

    // Fill to 8 bytes on the ce_2 phase, then free-space threshold
    ce_1 = 1'b0;
    ce_2 = 1'b1;
    redirect(16'h0100, 1'b1, "fill");
    for (int k = 0; k < 4; k++) begin
      q_addr.push_back(16'h0100 + 16'(2 * k));
      wait_req($sformatf("fill%0d", k));
      chk_addr($sformatf("fill%0d_addr", k));
      do_ack();
      do_valid({8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k)});
    end
    for (int i = 0; i < 3; i++)
      tick();
    chk("full_req", 32'(fetch_req), 32'd0);
    chk("full_len", 32'(ipq_len), 32'd8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("full_ipq%0d", j), 32'(ipq[j]),
          32'(8'h10 + j));
    ce_1 = 1'b1;
    ce_2 = 1'b0;
    pc = 16'h0101;
    for (int i = 0; i < 3; i++)
      tick();
    chk("free1_req", 32'(fetch_req), 32'd0);
    chk("free1_len", 32'(ipq_len), 32'd7);
    pc = 16'h0102;
    q_addr.push_back(16'h0108);
    wait_req("free2");
    chk_addr("free2_addr");

    // Flush while a transaction is outstanding
    do_ack();
    redirect(16'h3000, 1'b0, "outst");
    tick();
    tick();
    chk("outst_wait_req", 32'(fetch_req), 32'd0);
    do_valid(16'hFFFF);
    tick();
    chk("outst_len", 32'(ipq_len), 32'd0);
    chk("outst_keep", 32'(ipq[0]), 32'h10);
    q_addr.push_back(16'h3000);
    wait_req("outst_new");
    chk_addr("outst_new_addr");

    // Flush coincident with ack, gated valid, then wrap fill
    set_pc    = 1'b1;
    new_pc    = 16'hFFFC;
    pc        = 16'hFFFC;
    fetch_ack = 1'b1;
    tick();
    set_pc    = 1'b0;
    fetch_ack = 1'b0;
    chk("ackflush_req", 32'(fetch_req), 32'd0);
    ce_1 = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = 16'hBEEF;
    tick();
    tick();
    fetch_valid = 1'b0;
    ce_1 = 1'b1;
    tick();
    tick();
    chk("gated_valid_req", 32'(fetch_req), 32'd0);
    do_valid(16'hEEEE);
    tick();
    chk("ackflush_len", 32'(ipq_len), 32'd0);
    for (int k = 0; k < 4; k++) begin
      q_addr.push_back(16'hFFFC + 16'(2 * k));
      wait_req($sformatf("wrap%0d", k));
      chk_addr($sformatf("wrap%0d_addr", k));
      do_ack();
      do_valid({8'(8'h21 + 2 * k), 8'(8'h20 + 2 * k)});
    end
    for (int i = 0; i < 3; i++)
      tick();
    chk("wrap_len", 32'(ipq_len), 32'd8);
    chk("wrap_req", 32'(fetch_req), 32'd0);
    for (int j = 0; j < 8; j++)
      chk($sformatf("wrap_ipq%0d", j), 32'(ipq[j]),
          32'(8'h20 + ((j + 4) % 8)));
    chk("sb_empty", 32'(q_addr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nec_prefetch_queue.md
Name: nec_prefetch_queue

Overview:
- Instruction prefetch queue that sits directly upstream of the instruction decoder and feeds it `ipq[8]` and `ipq_len`.
- Issues 16-bit code fetches over a request/ack/valid handshake to the bus interface unit.
- Stores fetched bytes in an 8-entry circular buffer, indexed by the low three bits of each byte's address.
- Frees buffer space as the decoder's `pc` advances; flushes and restarts on `set_pc`.

Parameters:
- QUEUE_BYTES, 8, buffer depth. Fixed at 8: the decoder indexes with 3 bits.
- MIN_FREE_EVEN, 2, free bytes required before issuing a fetch from an even address (1–2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_1  in  1  phase-1 clock enable
- ce_2  in  1  phase-2 clock enable
- pc  in  16  decoder's current consume address (first unconsumed byte)
- set_pc  in  1  flush/redirect; same signal the decoder receives
- new_pc  in  16  redirect target address
- ipq  out  8x8  byte buffer; slot k holds the byte whose address[2:0] == k
- ipq_len  out  4  valid bytes starting at `pc`, range 0..8
- fetch_req  out  1  code fetch request to bus unit
- fetch_addr  out  16  word-aligned fetch address (bit 0 always 0)
- fetch_ack  in  1  bus unit accepted the request
- fetch_valid  in  1  single-cycle data-return strobe
- fetch_data  in  16  returned word; [7:0] = even byte, [15:8] = odd byte

Behaviour:
- Reset (async, `reset_n`=0):
  - `ipq` all 0x00, `ipq_len`=0, `fetch_req`=0, `fetch_addr`=0.
  - Internal state cleared: `fetch_ptr`=0, `outstanding`=0, `discard`=0, `running`=0.
- State updates occur only on cycles with `ce_1|ce_2`. `fetch_ack`, `fetch_valid` and `set_pc` are sampled only on those cycles.
- `running` is set by the first `set_pc`. While `running`=0, no request is issued and `ipq_len`=0.
- `fetch_ptr` (16 bit) is the address of the next byte to fetch.
- `ipq_len` = (`fetch_ptr` − `pc`) mod 16, registered each enabled cycle.
  - Invariant: the value never exceeds 8.
  - Free space = 8 − len.
- Request issue: when `running`, not `outstanding`, `fetch_req`=0, and free ≥ (`fetch_ptr[0]` ? 1 : MIN_FREE_EVEN):
  - assert `fetch_req`;
  - drive `fetch_addr` = {`fetch_ptr[15:1]`, 0}.
- Handshake:
  - `fetch_req` and `fetch_addr` are held stable until `fetch_ack`.
  - On ack: `fetch_req` drops, `outstanding`=1.
  - At most one transaction is outstanding.
  - `fetch_valid` without `outstanding` is ignored.
- Data return (`fetch_valid` & `outstanding` & ~`discard`):
  - Even `fetch_ptr`: write `ipq[fetch_ptr[2:0]]` ← data[7:0] and `ipq[fetch_ptr[2:0]+1]` ← data[15:8]; `fetch_ptr` += 2.
  - Odd `fetch_ptr`: write only `ipq[fetch_ptr[2:0]]` ← data[15:8]; `fetch_ptr` += 1.
  - Clear `outstanding`.
  - The new len is visible on the next enabled cycle.
- Flush (`set_pc`):
  - `fetch_ptr` ← `new_pc`, `running`=1, `ipq_len` ← 0.
  - If `fetch_req` is pending and unacked: the request stays asserted with its old address (bus protocol). Set `discard`=1, held until that transaction's data returns.
  - If `outstanding`: set `discard`=1.
  - Data returning with `discard`=1 is dropped; clear `discard` and `outstanding`. A new request may issue on the following enabled cycle.
  - `set_pc` in the same cycle as `fetch_valid`: the data is dropped and the flush wins.
  - `set_pc` in the same cycle as `fetch_ack`: the ack is honoured and `discard` is set.
- Address wrap: `fetch_ptr` and length arithmetic are modulo 2^16. Fetching across 0xFFFF→0x0000 is legal.
- Buffer wrap: slot index is `fetch_ptr[2:0]`, naturally modulo 8.
- Consumption is implicit: bytes below `pc` are free. `ipq` contents are not cleared on consume or flush.
- Decoder `pc` advancing beyond `fetch_ptr` is illegal. Bench asserts len ≤ 8.

Decomposition:
- Add to `types` package:
  - `prefetch_state_e` (PF_IDLE, PF_REQ, PF_WAIT);
  - localparam `IPQ_BYTES`=8.
- One natural sub-module, `nec_prefetch_req`: the request/ack/discard handshake FSM.
  - IDLE→REQ on issue condition.
  - REQ→WAIT on ack.
  - WAIT→IDLE on valid.
  - Owns `discard`.
- Buffer write and length math stay in the top module.

Test Plan:
- Reset then `set_pc` `new_pc`=0x0100 → `fetch_req`=1, `fetch_addr`=0x0100. Ack, then valid with data 0xB890 → `ipq[0]`=0x90, `ipq[1]`=0xB8, `ipq_len`=2.
- Decoder `pc` held at 0x0100 with continuous 1-cycle bus → fetches at 0x0102, 0x0104, 0x0106. `ipq_len` reaches 8, and no further request while free < 2.
- `set_pc` `new_pc`=0x2003 → `fetch_addr`=0x2002. Data 0x55AA → only `ipq[3]`=0x55, `ipq_len`=1. Next fetch at 0x2004.
- `set_pc` while `outstanding`, then valid → data dropped, `ipq_len` stays 0. Next request uses the new address.
- `set_pc` while `fetch_req` is unacked → `fetch_addr` unchanged until ack. Returned data is dropped, then a request is issued at the new address.
- `pc`=0xFFFC, fill to wrap → fetches at 0xFFFC, 0xFFFE, 0x0000, 0x0002. Slots 4..7 then 0..3 are filled, and `ipq_len`=8.
